// File: rtl/pll_lock_sequencer_if.sv
// Control/status bundle between the PLL lock sequencer and the
// surrounding board logic. The sequencer side uses the master modport.
interface pll_lock_sequencer_if #(
  parameter int NUM_PLLS = 2
);
  logic [NUM_PLLS-1:0] pll_locked_in;
  logic                restart;
  logic [NUM_PLLS-1:0] pll_rst_n_out;
  logic                clk_ready;
  logic                domain_rst_n;
  logic                fault;
  logic [3:0]          retry_count;
  logic [7:0]          lock_loss_count;
  logic [2:0]          state_out;

  modport master (
    input  pll_locked_in,
    input  restart,
    output pll_rst_n_out,
    output clk_ready,
    output domain_rst_n,
    output fault,
    output retry_count,
    output lock_loss_count,
    output state_out
  );

  modport slave (
    output pll_locked_in,
    output restart,
    input  pll_rst_n_out,
    input  clk_ready,
    input  domain_rst_n,
    input  fault,
    input  retry_count,
    input  lock_loss_count,
    input  state_out
  );
endinterface

// File: rtl/pll_lock_sequencer.sv
// PLL power-up / recovery sequencer. Holds every PLL in reset, releases
// them one at a time once the previous one shows a stable lock, then
// releases the downstream domain reset. Timeouts and lock losses during
// bring-up are retried a bounded number of times before latching FAULT.
module pll_lock_sequencer #(
  parameter int NUM_PLLS            = 2,
  parameter int RESET_HOLD_CYCLES   = 16,
  parameter int LOCK_TIMEOUT_CYCLES = 27000,
  parameter int LOCK_STABLE_CYCLES  = 256,
  parameter int READY_DELAY_CYCLES  = 64,
  parameter int MAX_RETRIES         = 3
) (
  input  logic                  clk_in,
  input  logic                  reset_n,
  pll_lock_sequencer_if.master  bus
);

  // Counter width helper: never below one bit so degenerate parameters still elaborate.
  function automatic int cw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int HW = cw(RESET_HOLD_CYCLES);
  localparam int OW = cw(LOCK_TIMEOUT_CYCLES);
  localparam int RW = cw(READY_DELAY_CYCLES);
  // One shared phase timer covers HOLD length, ENABLE timeout and SETTLE delay.
  localparam int TW = (HW > OW) ? ((HW > RW) ? HW : RW) : ((OW > RW) ? OW : RW);
  localparam int SW = cw(LOCK_STABLE_CYCLES);
  localparam int IW = cw(NUM_PLLS);

  localparam logic [TW-1:0] HOLD_LAST    = TW'(RESET_HOLD_CYCLES - 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] READY_LAST   = TW'(READY_DELAY_CYCLES - 1);
  localparam logic [SW-1:0] STABLE_LAST  = SW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST     = IW'(NUM_PLLS - 1);

  if (LOCK_STABLE_CYCLES < 1 || LOCK_TIMEOUT_CYCLES <= LOCK_STABLE_CYCLES) begin : g_param_check
    $error("pll_lock_sequencer: need LOCK_STABLE_CYCLES >= 1 and LOCK_TIMEOUT_CYCLES > LOCK_STABLE_CYCLES");
  end

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    HOLD   = 3'd1,
    ENABLE = 3'd2,
    SETTLE = 3'd3,
    RUN    = 3'd4,
    FAULT  = 3'd5
  } state_t;

  state_t              state_q, state_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [TW-1:0]       timer_q, timer_d;
  logic [SW-1:0]       stable_q, stable_d;
  logic [3:0]          retry_q, retry_d;
  logic [7:0]          loss_q, loss_d;
  logic [NUM_PLLS-1:0] sync1_q, lock_sync_q;
  logic [NUM_PLLS-1:0] pll_rst_n_q, pll_rst_n_d;
  logic                clk_ready_q, fault_q;

  logic [NUM_PLLS-1:0] lower_mask;
  logic [NUM_PLLS-1:0] enable_mask_d;
  logic                cur_lock;
  logic                all_lock;
  logic                lower_loss;
  logic                fail;
  logic [3:0]          retry_inc;

  // Per-PLL masks: PLLs below the one being brought up, and PLLs released in the next state.
  for (genvar gi = 0; gi < NUM_PLLS; gi++) begin : g_mask
    assign lower_mask[gi]    = (IW'(gi) <  idx_q);
    assign enable_mask_d[gi] = (IW'(gi) <= idx_d);
  end

  assign cur_lock   = lock_sync_q[idx_q];
  assign all_lock   = &lock_sync_q;
  assign lower_loss = |(lower_mask & ~lock_sync_q);
  assign retry_inc  = (retry_q == 4'hF) ? retry_q : retry_q + 4'd1;

  // Two-flop synchronizer for the asynchronous PLL lock indications.
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q     <= '0;
      lock_sync_q <= '0;
    end else begin
      sync1_q     <= bus.pll_locked_in;
      lock_sync_q <= sync1_q;
    end
  end

  // Next-state, counter and failure decisions for the bring-up sequence.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    timer_d  = timer_q;
    stable_d = stable_q;
    retry_d  = retry_q;
    loss_d   = loss_q;
    fail     = 1'b0;

    case (state_q)
      IDLE: begin
        state_d = HOLD;
        timer_d = '0;
      end
      HOLD: begin
        if (timer_q == HOLD_LAST) begin
          state_d  = ENABLE;
          idx_d    = '0;
          timer_d  = '0;
          stable_d = '0;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      ENABLE: begin
        timer_d  = timer_q + TW'(1);
        stable_d = cur_lock ? stable_q + SW'(1) : '0;
        if (lower_loss) begin
          fail = 1'b1;
        end else if (cur_lock && stable_q == STABLE_LAST) begin
          // Stable lock wins over a timeout expiring in the same cycle.
          if (idx_q == IDX_LAST) begin
            state_d = SETTLE;
          end else begin
            idx_d = idx_q + IW'(1);
          end
          timer_d  = '0;
          stable_d = '0;
        end else if (timer_q == TIMEOUT_LAST) begin
          fail = 1'b1;
        end
      end
      SETTLE: begin
        if (!all_lock) begin
          fail = 1'b1;
        end else if (timer_q == READY_LAST) begin
          state_d = RUN;
          timer_d = '0;
          retry_d = '0;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      RUN: begin
        // Loss of lock in service is counted separately and does not use up retries.
        if (!all_lock) begin
          state_d = HOLD;
          timer_d = '0;
          loss_d  = (loss_q == 8'hFF) ? loss_q : loss_q + 8'd1;
        end
      end
      FAULT: begin
        if (bus.restart) begin
          state_d = HOLD;
          timer_d = '0;
          retry_d = '0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (fail) begin
      retry_d  = retry_inc;
      timer_d  = '0;
      stable_d = '0;
      state_d  = (int'(retry_inc) >= MAX_RETRIES) ? FAULT : HOLD;
    end
  end

  // PLL reset pattern for the upcoming state, so the output register matches its first cycle.
  always_comb begin
    pll_rst_n_d = '0;
    case (state_d)
      ENABLE:      pll_rst_n_d = enable_mask_d;
      SETTLE, RUN: pll_rst_n_d = '1;
      default:     pll_rst_n_d = '0;
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      timer_q     <= '0;
      stable_q    <= '0;
      retry_q     <= '0;
      loss_q      <= '0;
      pll_rst_n_q <= '0;
      clk_ready_q <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      timer_q     <= timer_d;
      stable_q    <= stable_d;
      retry_q     <= retry_d;
      loss_q      <= loss_d;
      pll_rst_n_q <= pll_rst_n_d;
      clk_ready_q <= (state_d == RUN);
      fault_q     <= (state_d == FAULT);
    end
  end

  assign bus.pll_rst_n_out   = pll_rst_n_q;
  assign bus.clk_ready       = clk_ready_q;
  assign bus.domain_rst_n    = clk_ready_q;
  assign bus.fault           = fault_q;
  assign bus.retry_count     = retry_q;
  assign bus.lock_loss_count = loss_q;
  assign bus.state_out       = state_q;

endmodule
